// File: rtl/riscv_proc_ctrl_wb_sched.sv
// rtl/riscv_proc_ctrl_wb_sched.sv - two-port round-robin writeback scheduler with optional busy scoreboard
// Define RISCV_WB_SCOREBOARD_EN to build the register busy vector and decode stall logic.
module riscv_proc_ctrl_wb_sched (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req_val,
  output logic [3:0]   req_rdy,
  input  logic [19:0]  req_waddr,
  input  logic [255:0] req_wdata,
  output logic         wen0_p,
  output logic         wen1_p,
  output logic [4:0]   waddr0_p,
  output logic [4:0]   waddr1_p,
  output logic [63:0]  wdata0_p,
  output logic [63:0]  wdata1_p,
  input  logic         issue_val,
  input  logic [4:0]   issue_waddr,
  input  logic [4:0]   chk_raddr0,
  input  logic [4:0]   chk_raddr1,
  input  logic [4:0]   chk_waddr,
  input  logic         chk_ren0,
  input  logic         chk_ren1,
  input  logic         chk_wen,
  output logic         stall
);

  logic [1:0]  rr;
  logic [4:0]  waddr_a [4];
  logic [63:0] wdata_a [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      waddr_a[i] = req_waddr[5*i +: 5];
      wdata_a[i] = req_wdata[64*i +: 64];
    end
  end

  logic       g0_vld, g1_vld;
  logic [1:0] g0_idx, g1_idx;
  logic [1:0] cand;

  // Port 1 skips any candidate targeting the same register as port 0; it retries later.
  always_comb begin
    g0_vld = 1'b0;
    g1_vld = 1'b0;
    g0_idx = 2'd0;
    g1_idx = 2'd0;
    cand   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = rr + 2'(k);
      if (req_val[cand]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_idx = cand;
        end else if (!g1_vld && (waddr_a[cand] != waddr_a[g0_idx])) begin
          g1_vld = 1'b1;
          g1_idx = cand;
        end
      end
    end
  end

  always_comb begin
    req_rdy = 4'b0000;
    if (!reset) begin
      if (g0_vld) req_rdy[g0_idx] = 1'b1;
      if (g1_vld) req_rdy[g1_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr       <= 2'd0;
      wen0_p   <= 1'b0;
      wen1_p   <= 1'b0;
      waddr0_p <= 5'd0;
      waddr1_p <= 5'd0;
      wdata0_p <= 64'd0;
      wdata1_p <= 64'd0;
    end else begin
      // Writes to x0 are accepted from the requester but never reach the regfile.
      wen0_p   <= g0_vld && (waddr_a[g0_idx] != 5'd0);
      wen1_p   <= g1_vld && (waddr_a[g1_idx] != 5'd0);
      waddr0_p <= waddr_a[g0_idx];
      waddr1_p <= waddr_a[g1_idx];
      wdata0_p <= wdata_a[g0_idx];
      wdata1_p <= wdata_a[g1_idx];
      if (g1_vld)      rr <= g1_idx + 2'd1;
      else if (g0_vld) rr <= g0_idx + 2'd1;
    end
  end

`ifdef RISCV_WB_SCOREBOARD_EN
  logic [31:0] busy;
  logic [31:0] busy_nxt;

  // Clears come from the registered write ports; a same-cycle issue wins.
  always_comb begin
    busy_nxt = busy;
    if (wen0_p) busy_nxt[waddr0_p] = 1'b0;
    if (wen1_p) busy_nxt[waddr1_p] = 1'b0;
    if (issue_val) busy_nxt[issue_waddr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= 32'd0;
    else       busy <= busy_nxt;
  end

  always_comb begin
    stall = (chk_ren0 && busy[chk_raddr0]) ||
            (chk_ren1 && busy[chk_raddr1]) ||
            (chk_wen  && busy[chk_waddr]);
  end
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{issue_val, issue_waddr, chk_raddr0, chk_raddr1,
                              chk_waddr, chk_ren0, chk_ren1, chk_wen};
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_proc_ctrl_wb_sched.sv
// tb/tb_riscv_proc_ctrl_wb_sched.sv - randomized and directed check of the writeback scheduler against a reference model
module tb_riscv_proc_ctrl_wb_sched;

`ifdef RISCV_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_val;
  logic [3:0]   req_rdy;
  logic [19:0]  req_waddr;
  logic [255:0] req_wdata;
  logic         wen0_p, wen1_p;
  logic [4:0]   waddr0_p, waddr1_p;
  logic [63:0]  wdata0_p, wdata1_p;
  logic         issue_val;
  logic [4:0]   issue_waddr;
  logic [4:0]   chk_raddr0, chk_raddr1, chk_waddr;
  logic         chk_ren0, chk_ren1, chk_wen;
  logic         stall;

  always #5 clk = ~clk;

  riscv_proc_ctrl_wb_sched dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_waddr(req_waddr), .req_wdata(req_wdata),
    .wen0_p(wen0_p), .wen1_p(wen1_p), .waddr0_p(waddr0_p), .waddr1_p(waddr1_p),
    .wdata0_p(wdata0_p), .wdata1_p(wdata1_p),
    .issue_val(issue_val), .issue_waddr(issue_waddr),
    .chk_raddr0(chk_raddr0), .chk_raddr1(chk_raddr1), .chk_waddr(chk_waddr),
    .chk_ren0(chk_ren0), .chk_ren1(chk_ren1), .chk_wen(chk_wen),
    .stall(stall)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: what the registered outputs should show right now.
  int          m_rr;
  bit          m_busy [32];
  bit          m_wen  [2];
  int          m_wa   [2];
  logic [63:0] m_wd   [2];

  function automatic int wa(input int i);
    return int'(req_waddr[5*i +: 5]);
  endfunction

  function automatic logic [63:0] wd(input int i);
    return req_wdata[64*i +: 64];
  endfunction

  task automatic arb(output int ga, output int gb);
    ga = -1;
    gb = -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_rr + k) % 4;
      if (req_val[i]) begin
        if (ga < 0) ga = i;
        else if (gb < 0 && wa(i) != wa(ga)) gb = i;
      end
    end
  endtask

  task automatic model_reset();
    m_rr = 0;
    for (int n = 0; n < 32; n++) m_busy[n] = 1'b0;
    m_wen[0] = 1'b0;
    m_wen[1] = 1'b0;
  endtask

  // Check one cycle's outputs against the model, then clock and advance the model.
  task automatic step();
    int ga, gb;
    logic [3:0] er;
    bit est;
    #1;
    arb(ga, gb);
    er = 4'b0000;
    if (!reset) begin
      if (ga >= 0) er[ga] = 1'b1;
      if (gb >= 0) er[gb] = 1'b1;
    end
    check("req_rdy", {60'd0, req_rdy}, {60'd0, er});
    check("wen0_p", {63'd0, wen0_p}, {63'd0, m_wen[0]});
    check("wen1_p", {63'd0, wen1_p}, {63'd0, m_wen[1]});
    if (m_wen[0]) begin
      check("waddr0_p", {59'd0, waddr0_p}, 64'(m_wa[0]));
      check("wdata0_p", wdata0_p, m_wd[0]);
    end
    if (m_wen[1]) begin
      check("waddr1_p", {59'd0, waddr1_p}, 64'(m_wa[1]));
      check("wdata1_p", wdata1_p, m_wd[1]);
    end
    est = SB && ((chk_ren0 && m_busy[chk_raddr0]) || (chk_ren1 && m_busy[chk_raddr1]) ||
                 (chk_wen && m_busy[chk_waddr]));
    check("stall", {63'd0, stall}, {63'd0, est});
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (m_wen[0]) m_busy[m_wa[0]] = 1'b0;
      if (m_wen[1]) m_busy[m_wa[1]] = 1'b0;
      if (issue_val && issue_waddr != 5'd0) m_busy[issue_waddr] = 1'b1;
      m_wen[0] = (ga >= 0) && (wa(ga) != 0);
      m_wen[1] = (gb >= 0) && (wa(gb) != 0);
      if (ga >= 0) begin m_wa[0] = wa(ga); m_wd[0] = wd(ga); end
      if (gb >= 0) begin m_wa[1] = wa(gb); m_wd[1] = wd(gb); end
      if (gb >= 0)      m_rr = (gb + 1) % 4;
      else if (ga >= 0) m_rr = (ga + 1) % 4;
    end
    #1;
  endtask

  task automatic idle_inputs();
    req_val   = 4'b0000;
    issue_val = 1'b0;
    chk_ren0  = 1'b0;
    chk_ren1  = 1'b0;
    chk_wen   = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    req_waddr   = 20'd0;
    req_wdata   = {4{64'h0123_4567_89ab_cdef}};
    issue_waddr = 5'd0;
    chk_raddr0  = 5'd0;
    chk_raddr1  = 5'd0;
    chk_waddr   = 5'd0;
    @(posedge clk);
    #1;
    model_reset();
    step();
    reset = 1'b0;

    // Four distinct requesters from rr=0.
    req_val   = 4'b1111;
    req_waddr = {5'd4, 5'd3, 5'd2, 5'd1};
    for (int i = 0; i < 4; i++) req_wdata[64*i +: 64] = 64'h1000 + 64'(i);
    #1 check("r29_rdy", {60'd0, req_rdy}, 64'h3);
    step();
    #1 check("r29_wen", {62'd0, wen1_p, wen0_p}, 64'h3);
    check("r29_wa0", {59'd0, waddr0_p}, 64'd1);
    check("r29_wa1", {59'd0, waddr1_p}, 64'd2);
    check("r29_rr2", {60'd0, req_rdy}, 64'hc);
    step();

    // Two requesters targeting the same register.
    req_val   = 4'b0101;
    req_waddr = {5'd7, 5'd7, 5'd7, 5'd7};
    #1 check("r30_rdy", {60'd0, req_rdy}, 64'h1);
    step();
    req_val = 4'b0100;
    #1 check("r30_rdy2", {60'd0, req_rdy}, 64'h4);
    step();
    req_val = 4'b0000;
    #1 check("r30_wen0", {63'd0, wen0_p}, 64'd1);
    check("r30_wa0", {59'd0, waddr0_p}, 64'd7);
    step();

    // Issue to x5, read it, then retire it.
    issue_val = 1'b1; issue_waddr = 5'd5;
    step();
    issue_val = 1'b0; chk_ren0 = 1'b1; chk_raddr0 = 5'd5;
    #1 check("r31_stall", {63'd0, stall}, {63'd0, SB});
    step();
    req_val = 4'b0001; req_waddr = {5'd0, 5'd0, 5'd0, 5'd5};
    step();
    req_val = 4'b0000;
    #1 check("r31_wen", {63'd0, wen0_p | wen1_p}, 64'd1);
    step();
    #1 check("r31_clr", {63'd0, stall}, 64'd0);
    step();

    // Same-cycle set and clear of x9.
    chk_ren0 = 1'b0;
    issue_val = 1'b1; issue_waddr = 5'd9;
    step();
    issue_val = 1'b0;
    req_val = 4'b0001; req_waddr = {5'd0, 5'd0, 5'd0, 5'd9};
    step();
    req_val = 4'b0000;
    issue_val = 1'b1; issue_waddr = 5'd9;
    #1 check("r32_wa", {59'd0, waddr0_p}, 64'd9);
    step();
    issue_val = 1'b0; chk_ren0 = 1'b1; chk_raddr0 = 5'd9;
    #1 check("r32_stall", {63'd0, stall}, {63'd0, SB});
    step();

    // Write to x0 is accepted but never enabled.
    req_val = 4'b0001; req_waddr = 20'd0; req_wdata[63:0] = 64'hdead;
    #1 check("r33_rdy", {60'd0, req_rdy}, 64'h1);
    step();
    req_val = 4'b0000;
    #1 check("r33_wen", {62'd0, wen1_p, wen0_p}, 64'd0);
    check("r33_stall", {63'd0, stall}, {63'd0, SB});
    step();

    // Reset during a handshake with x9 still busy.
    reset = 1'b1;
    req_val = 4'b1111; req_waddr = {5'd4, 5'd3, 5'd2, 5'd1};
    #1 check("r34_rdy", {60'd0, req_rdy}, 64'h0);
    step();
    reset = 1'b0;
    req_val = 4'b0000;
    #1 check("r34_wen", {62'd0, wen1_p, wen0_p}, 64'd0);
    check("r34_stall", {63'd0, stall}, 64'd0);
    req_val = 4'b1111;
    #1 check("r34_rr0", {60'd0, req_rdy}, 64'h3);
    step();
    idle_inputs();

    for (int c = 0; c < 600; c++) begin
      reset       = ($urandom_range(0, 39) == 0);
      req_val     = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        req_waddr[5*i +: 5]   = 5'($urandom_range(0, 7));
        req_wdata[64*i +: 64] = {$urandom, $urandom};
      end
      issue_val   = 1'($urandom);
      issue_waddr = 5'($urandom_range(0, 7));
      chk_ren0    = 1'($urandom);
      chk_ren1    = 1'($urandom);
      chk_wen     = 1'($urandom);
      chk_raddr0  = 5'($urandom_range(0, 7));
      chk_raddr1  = 5'($urandom_range(0, 7));
      chk_waddr   = 5'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
